word_dispatch: RTL

//  Single-clock scheduler between the word-list output FIFO and N crypt cores.

---
 rtl/word_dispatch_pkg.sv | 27 ++
 rtl/word_dispatch_rr_arbiter.sv | 35 +++
 rtl/word_dispatch.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/word_dispatch_pkg.sv
// Shared definitions for the word dispatcher: MSB helper macro, FSM state
// encoding and small index helpers used by the top and the arbiter.
`ifndef WORD_DISPATCH_MSB_DEFINED
`define WORD_DISPATCH_MSB_DEFINED
// Index of the most significant set bit of a positive constant.
`define MSB(x) ($clog2((x) + 1) - 1)
`endif

package word_dispatch_pkg;

  // Dispatcher FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Width of a core index; a single core still gets a one-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Increment modulo n, used to move the round-robin pointer past a grantee.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return ((v + 1) >= n) ? 0 : (v + 1);
  endfunction

endpackage

// File: rtl/word_dispatch_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting core at or
// above ptr_i, wrapping at N-1. Produces a one-hot grant, its index and a
// valid flag.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             vld_o
);

  logic [PTR_W-1:0] cand;
  logic             found;

  // Scan N candidates starting at the pointer; the first requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = PTR_W'((int'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        idx_o        = cand;
        gnt_o[cand]  = 1'b1;
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/word_dispatch.sv
// word_dispatch: pops words from the show-ahead word-list FIFO one at a time,
// hands each to a non-full crypt core round-robin over a shared bus, and
// pulses list_done once the last word of a list is out and all cores are idle.
// Optional build macro: DISPATCH_STATS_EN adds saturating stat_words /
// stat_stalls counters and their output ports.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | wait for a FIFO entry; pop it (skip empty entries)
//  HOLD  | word on the bus, waiting for a non-full core to take it
//  DRAIN | list end seen, waiting for every core to go idle
//  DONE  | single-cycle list_done pulse
module word_dispatch
  import word_dispatch_pkg::*;
#(
  parameter int N_CORES      = 4,
  parameter int CHAR_BITS    = 7,
  parameter int WORD_MAX_LEN = 8,
  localparam int LEN_W  = `MSB(WORD_MAX_LEN) + 1,
  localparam int WORD_W = WORD_MAX_LEN * CHAR_BITS,
  localparam int PTR_W  = ptr_width(N_CORES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  wl_dout,
  input  logic [LEN_W-1:0]   wl_word_len,
  input  logic [15:0]        wl_word_id,
  input  logic               wl_word_list_end,
  input  logic               wl_empty,
  output logic               wl_rd_en,
  output logic [WORD_W-1:0]  core_word,
  output logic [LEN_W-1:0]   core_word_len,
  output logic [15:0]        core_word_id,
  output logic [N_CORES-1:0] core_wr_en,
  input  logic [N_CORES-1:0] core_full,
  input  logic [N_CORES-1:0] core_idle,
  output logic               list_done
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]        stat_words,
  output logic [31:0]        stat_stalls
`endif
);

  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [WORD_W-1:0]  word_q;
  logic [LEN_W-1:0]   len_q;
  logic [15:0]        id_q;
  logic               end_q;

  logic               pop;
  logic               entry_empty;
  logic               dispatch;

  logic [N_CORES-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_vld;

  // Popping is gated by rst_n so no entry is consumed while the hold register
  // is held in reset (it would otherwise be lost).
  assign pop         = rst_n && (state_q == ST_IDLE) && !wl_empty;
  assign entry_empty = (wl_word_len == '0);
  assign dispatch    = (state_q == ST_HOLD) && arb_vld;

  rr_arbiter #(
    .N     (N_CORES),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req_i (~core_full),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // Next-state and round-robin pointer update.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          if (entry_empty) begin
            state_d = wl_word_list_end ? ST_DRAIN : ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (dispatch) begin
          rr_ptr_d = PTR_W'(wrap_inc(32'(arb_idx), N_CORES));
          state_d  = end_q ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if ((&core_idle) && !dispatch) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and pointer registers; the pointer survives across lists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Hold register: captures real words only, so the shared bus keeps the last
  // dispatched word while empty entries are skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
      end_q  <= 1'b0;
    end else if (pop && !entry_empty) begin
      word_q <= wl_dout;
      len_q  <= wl_word_len;
      id_q   <= wl_word_id;
      end_q  <= wl_word_list_end;
    end
  end

  assign wl_rd_en      = pop;
  assign core_word     = word_q;
  assign core_word_len = len_q;
  assign core_word_id  = id_q;
  assign core_wr_en    = dispatch ? arb_gnt : '0;
  assign list_done     = (state_q == ST_DONE);

`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_words_q;
  logic [31:0] stat_stalls_q;

  // Saturating counters: dispatched words and HOLD cycles with every core full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (dispatch && (stat_words_q != 32'hFFFF_FFFF)) begin
        stat_words_q <= stat_words_q + 32'd1;
      end
      if ((state_q == ST_HOLD) && !arb_vld && (stat_stalls_q != 32'hFFFF_FFFF)) begin
        stat_stalls_q <= stat_stalls_q + 32'd1;
      end
    end
  end

  assign stat_words  = stat_words_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule
